// File: rtl/chip8_alu_sequencer_if.sv
// Decoder / register-file / ALU bus seen by the CHIP-8 8XYN sequencer.
// master is the sequencer's view; slave is the surrounding decoder, register file and ALU.
interface chip8_alu_sequencer_if;
  logic        start;
  logic [3:0]  op_n;
  logic [3:0]  op_x;
  logic [3:0]  op_y;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_rd_data;
  logic        reg_we;
  logic [7:0]  reg_wr_data;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_carry;

  modport master (
    input  start, op_n, op_x, op_y, reg_rd_data, alu_out, alu_carry,
    output busy, done, illegal, reg_addr, reg_we, reg_wr_data, alu_in1, alu_in2, alu_sel
  );

  modport slave (
    output start, op_n, op_x, op_y, reg_rd_data, alu_out, alu_carry,
    input  busy, done, illegal, reg_addr, reg_we, reg_wr_data, alu_in1, alu_in2, alu_sel
  );
endinterface

// File: rtl/chip8_alu_sequencer.sv
// Runs one CHIP-8 8XYN instruction: read Vx/Vy, ALU flag pass, ALU result pass,
// then write Vx followed by VF. All bus outputs are registered.
module chip8_alu_sequencer #(
  parameter bit QUIRK_SHIFT_VY = 1'b0,
  parameter bit QUIRK_VF_RESET = 1'b0
) (
  input logic                   clk,
  input logic                   reset_n,
  chip8_alu_sequencer_if.master bus
);

  localparam int unsigned REG_W = 8;
  localparam int unsigned IDX_W = 4;

  localparam logic [IDX_W-1:0] REG_VF = 4'hF;

  localparam logic [3:0] N_MOV  = 4'h0;
  localparam logic [3:0] N_OR   = 4'h1;
  localparam logic [3:0] N_AND  = 4'h2;
  localparam logic [3:0] N_XOR  = 4'h3;
  localparam logic [3:0] N_ADD  = 4'h4;
  localparam logic [3:0] N_SUB  = 4'h5;
  localparam logic [3:0] N_SHR  = 4'h6;
  localparam logic [3:0] N_SUBN = 4'h7;
  localparam logic [3:0] N_SHL  = 4'hE;

  localparam logic [3:0] SEL_NONE = 4'h0;
  localparam logic [3:0] SEL_OR   = 4'h1;
  localparam logic [3:0] SEL_AND  = 4'h2;
  localparam logic [3:0] SEL_XOR  = 4'h3;
  localparam logic [3:0] SEL_ADD  = 4'h4;
  localparam logic [3:0] SEL_SUB  = 4'h5;
  localparam logic [3:0] SEL_SHL  = 4'h6;
  localparam logic [3:0] SEL_SHR  = 4'h7;
  localparam logic [3:0] SEL_GT   = 4'h9;
  localparam logic [3:0] SEL_LSB  = 4'hA;
  localparam logic [3:0] SEL_MSB  = 4'hB;

  typedef enum logic [3:0] {
    IDLE, RD_X, RD_Y, CAP_Y, FLAG, CALC, WR_X, WR_F, DONE, ILLEGAL
  } state_t;

  typedef struct packed {
    logic [3:0]       sel;
    logic [REG_W-1:0] a;
    logic [REG_W-1:0] b;
  } alu_req_t;

  state_t           state;
  logic [3:0]       n_q;
  logic [IDX_W-1:0] x_q;
  logic [IDX_W-1:0] y_q;
  logic [REG_W-1:0] vx_q;
  logic [REG_W-1:0] vy_q;
  logic             flag_q;

  function automatic logic is_legal(input logic [3:0] n);
    return (n <= N_SUBN) || (n == N_SHL);
  endfunction

  function automatic logic has_flag(input logic [3:0] n);
    return (n == N_ADD) || (n == N_SUB) || (n == N_SHR) || (n == N_SUBN) || (n == N_SHL);
  endfunction

  function automatic logic is_vf_reset(input logic [3:0] n);
    return QUIRK_VF_RESET && ((n == N_OR) || (n == N_AND) || (n == N_XOR));
  endfunction

  // Vy is still arriving on the read port when the first ALU pass is set up
  logic [REG_W-1:0] vy_c;
  logic [REG_W-1:0] src_c;
  alu_req_t         flag_req_c;
  alu_req_t         calc_req_c;
  alu_req_t         next_req_c;
  logic             flag_c;

  always_comb begin
    vy_c  = (state == CAP_Y) ? bus.reg_rd_data : vy_q;
    src_c = QUIRK_SHIFT_VY ? vy_c : vx_q;

    flag_req_c = '0;
    case (n_q)
      N_ADD:   flag_req_c = '{sel: SEL_ADD, a: vx_q,  b: vy_c};
      N_SUB:   flag_req_c = '{sel: SEL_GT,  a: vy_c,  b: vx_q};
      N_SUBN:  flag_req_c = '{sel: SEL_GT,  a: vx_q,  b: vy_c};
      N_SHR:   flag_req_c = '{sel: SEL_LSB, a: src_c, b: 8'h00};
      N_SHL:   flag_req_c = '{sel: SEL_MSB, a: src_c, b: 8'h00};
      default: flag_req_c = '0;
    endcase

    calc_req_c = '0;
    case (n_q)
      N_MOV:   calc_req_c = '{sel: SEL_OR,  a: vy_c,  b: 8'h00};
      N_OR:    calc_req_c = '{sel: SEL_OR,  a: vx_q,  b: vy_c};
      N_AND:   calc_req_c = '{sel: SEL_AND, a: vx_q,  b: vy_c};
      N_XOR:   calc_req_c = '{sel: SEL_XOR, a: vx_q,  b: vy_c};
      N_ADD:   calc_req_c = '{sel: SEL_ADD, a: vx_q,  b: vy_c};
      N_SUB:   calc_req_c = '{sel: SEL_SUB, a: vx_q,  b: vy_c};
      N_SUBN:  calc_req_c = '{sel: SEL_SUB, a: vy_c,  b: vx_q};
      N_SHR:   calc_req_c = '{sel: SEL_SHR, a: src_c, b: 8'h01};
      N_SHL:   calc_req_c = '{sel: SEL_SHL, a: src_c, b: 8'h01};
      default: calc_req_c = '0;
    endcase

    next_req_c = ((state == CAP_Y) && has_flag(n_q)) ? flag_req_c : calc_req_c;

    // Subtract ops report "no borrow", i.e. the inverse of the strict compare
    case (n_q)
      N_ADD:         flag_c = bus.alu_carry;
      N_SUB, N_SUBN: flag_c = ~bus.alu_out[0];
      default:       flag_c = bus.alu_out[0];
    endcase
  end

  // State machine with registered bus outputs; strobes default low every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      n_q             <= '0;
      x_q             <= '0;
      y_q             <= '0;
      vx_q            <= '0;
      vy_q            <= '0;
      flag_q          <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.illegal     <= 1'b0;
      bus.reg_addr    <= '0;
      bus.reg_we      <= 1'b0;
      bus.reg_wr_data <= '0;
      bus.alu_in1     <= '0;
      bus.alu_in2     <= '0;
      bus.alu_sel     <= SEL_NONE;
    end else begin
      bus.done        <= 1'b0;
      bus.illegal     <= 1'b0;
      bus.reg_we      <= 1'b0;
      bus.reg_addr    <= '0;
      bus.reg_wr_data <= '0;
      bus.alu_in1     <= '0;
      bus.alu_in2     <= '0;
      bus.alu_sel     <= SEL_NONE;

      case (state)
        IDLE: begin
          if (bus.start) begin
            n_q      <= bus.op_n;
            x_q      <= bus.op_x;
            y_q      <= bus.op_y;
            bus.busy <= 1'b1;
            if (is_legal(bus.op_n)) begin
              state        <= RD_X;
              bus.reg_addr <= bus.op_x;
            end else begin
              state       <= ILLEGAL;
              bus.illegal <= 1'b1;
            end
          end
        end
        RD_X: begin
          state        <= RD_Y;
          bus.reg_addr <= y_q;
        end
        RD_Y: begin
          state <= CAP_Y;
          vx_q  <= bus.reg_rd_data;
        end
        CAP_Y: begin
          state       <= has_flag(n_q) ? FLAG : CALC;
          vy_q        <= bus.reg_rd_data;
          bus.alu_sel <= next_req_c.sel;
          bus.alu_in1 <= {8'h00, next_req_c.a};
          bus.alu_in2 <= {8'h00, next_req_c.b};
        end
        FLAG: begin
          state       <= CALC;
          flag_q      <= flag_c;
          bus.alu_sel <= next_req_c.sel;
          bus.alu_in1 <= {8'h00, next_req_c.a};
          bus.alu_in2 <= {8'h00, next_req_c.b};
        end
        CALC: begin
          state           <= WR_X;
          bus.reg_we      <= 1'b1;
          bus.reg_addr    <= x_q;
          bus.reg_wr_data <= bus.alu_out[REG_W-1:0];
        end
        WR_X: begin
          if (has_flag(n_q) || is_vf_reset(n_q)) begin
            state           <= WR_F;
            bus.reg_we      <= 1'b1;
            bus.reg_addr    <= REG_VF;
            bus.reg_wr_data <= is_vf_reset(n_q) ? 8'h00 : {7'b0, flag_q};
          end else begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        WR_F: begin
          state    <= DONE;
          bus.done <= 1'b1;
        end
        DONE, ILLEGAL: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Directed bench for chip8_alu_sequencer: instance 0 has both quirks off, instance 1 both on.
module tb_chip8_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chip8_alu_sequencer_if sif [2] ();

  logic             start_s [2];
  logic [3:0]       opn_s [2];
  logic [3:0]       opx_s [2];
  logic [3:0]       opy_s [2];
  logic [1:0]       busy_o, done_o, ill_o, we_o;
  logic [1:0][3:0]  sel_o;
  logic [7:0]       rf [2][16];

  typedef struct { int d; logic [3:0] a; logic [7:0] v; } wr_t;
  wr_t wlog [$];

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] alu_model(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      4'h1: return a | b;
      4'h2: return a & b;
      4'h3: return a ^ b;
      4'h4: return a + b;
      4'h5: return a - b;
      4'h6: return a << b;
      4'h7: return a >> b;
      4'h9: return {15'b0, a > b};
      4'hA: return {15'b0, a[0]};
      4'hB: return {15'b0, a[7]};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic carry_model(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [8:0] sum;
    sum = 9'(a[7:0]) + 9'(b[7:0]);
    return (s == 4'h4) && sum[8];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    chip8_alu_sequencer #(.QUIRK_SHIFT_VY(g == 1), .QUIRK_VF_RESET(g == 1)) u_dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (sif[g])
    );

    assign sif[g].start     = start_s[g];
    assign sif[g].op_n      = opn_s[g];
    assign sif[g].op_x      = opx_s[g];
    assign sif[g].op_y      = opy_s[g];
    assign sif[g].alu_out   = alu_model(sif[g].alu_sel, sif[g].alu_in1, sif[g].alu_in2);
    assign sif[g].alu_carry = carry_model(sif[g].alu_sel, sif[g].alu_in1, sif[g].alu_in2);
    assign busy_o[g] = sif[g].busy;
    assign done_o[g] = sif[g].done;
    assign ill_o[g]  = sif[g].illegal;
    assign we_o[g]   = sif[g].reg_we;
    assign sel_o[g]  = sif[g].alu_sel;

    // Register file with synchronous read, plus a log of every write
    always @(posedge clk) begin
      sif[g].reg_rd_data <= rf[g][sif[g].reg_addr];
      if (sif[g].reg_we) begin
        rf[g][sif[g].reg_addr] <= sif[g].reg_wr_data;
        wlog.push_back('{d: g, a: sif[g].reg_addr, v: sif[g].reg_wr_data});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input int d, input logic [3:0] x, input logic [3:0] y,
                         input logic [7:0] vx, input logic [7:0] vy);
    for (int i = 0; i < 16; i++) rf[d][i] <= 8'hA0 + 8'(i);
    rf[d][y] <= vy;
    rf[d][x] <= vx;
    @(negedge clk);
  endtask

  // Launches one op; cycle 0 is the cycle in which start is sampled
  task automatic run_op(input int d, input logic [3:0] n, input logic [3:0] x, input logic [3:0] y,
                        input int poke, output int done_cyc, output int busy_cnt,
                        output logic busy_after, output logic ill_seen);
    wlog.delete();
    start_s[d] = 1'b1; opn_s[d] = n; opx_s[d] = x; opy_s[d] = y;
    @(negedge clk);
    start_s[d] = 1'b0;
    done_cyc = 0; busy_cnt = 0; busy_after = 1'b1; ill_seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done_cyc != 0 && c == done_cyc + 1) begin
        busy_after = busy_o[d];
        break;
      end
      if (busy_o[d]) busy_cnt++;
      if (ill_o[d]) ill_seen = 1'b1;
      if (done_o[d] && done_cyc == 0) done_cyc = c;
      if (c == poke) begin
        start_s[d] = 1'b1; opn_s[d] = 4'h9;
      end else begin
        start_s[d] = 1'b0;
      end
      @(negedge clk);
    end
    start_s[d] = 1'b0;
    @(negedge clk);
    if (ill_o[d]) ill_seen = 1'b1;
  endtask

  typedef struct {
    int d; logic [3:0] n; logic [3:0] x; logic [3:0] y;
    logic [7:0] vx; logic [7:0] vy; logic [7:0] res; logic [7:0] vfw; logic [7:0] vf_fin;
    int nw; int dc;
  } vec_t;

  task automatic apply(input vec_t v, input int poke);
    int dc, bc;
    logic ba, ill;
    logic [11:0] w0, w1;
    string tag;
    tag = $sformatf("d%0d N%0h X%0h Y%0h", v.d, v.n, v.x, v.y);
    preload(v.d, v.x, v.y, v.vx, v.vy);
    run_op(v.d, v.n, v.x, v.y, poke, dc, bc, ba, ill);
    w0 = (wlog.size() > 0) ? {wlog[0].a, wlog[0].v} : 12'hFFF;
    w1 = (wlog.size() > 1) ? {wlog[1].a, wlog[1].v} : 12'hFFF;
    chk({tag, " done_cycle"}, 32'(dc), 32'(v.dc));
    chk({tag, " busy_cycles"}, 32'(bc), 32'(v.dc));
    chk({tag, " busy_after"}, 32'(ba), 32'(0));
    chk({tag, " no_illegal"}, 32'(ill), 32'(0));
    chk({tag, " write_count"}, 32'(wlog.size()), 32'(v.nw));
    chk({tag, " first_write"}, 32'(w0), 32'({v.x, v.res}));
    if (v.nw == 2) chk({tag, " vf_write"}, 32'(w1), 32'({4'hF, v.vfw}));
    if (v.x != 4'hF) chk({tag, " vx_final"}, 32'(rf[v.d][v.x]), 32'(v.res));
    chk({tag, " vf_final"}, 32'(rf[v.d][15]), 32'(v.vf_fin));
  endtask

  vec_t vecs [17];

  initial begin
    vecs[0]  = '{0, 4'h4, 4'h1, 4'h2, 8'hF0, 8'h20, 8'h10, 8'h01, 8'h01, 2, 8};
    vecs[1]  = '{0, 4'h5, 4'h3, 4'h4, 8'h05, 8'h07, 8'hFE, 8'h00, 8'h00, 2, 8};
    vecs[2]  = '{0, 4'h7, 4'h3, 4'h4, 8'h05, 8'h07, 8'h02, 8'h01, 8'h01, 2, 8};
    vecs[3]  = '{0, 4'h6, 4'hF, 4'h0, 8'h81, 8'h33, 8'h40, 8'h01, 8'h01, 2, 8};
    vecs[4]  = '{0, 4'h2, 4'h5, 4'h6, 8'h3C, 8'h0F, 8'h0C, 8'h00, 8'hAF, 1, 6};
    vecs[5]  = '{1, 4'h2, 4'h5, 4'h6, 8'h3C, 8'h0F, 8'h0C, 8'h00, 8'h00, 2, 7};
    vecs[6]  = '{0, 4'h0, 4'h7, 4'h8, 8'h11, 8'h99, 8'h99, 8'h00, 8'hAF, 1, 6};
    vecs[7]  = '{0, 4'h1, 4'h7, 4'h8, 8'h11, 8'h82, 8'h93, 8'h00, 8'hAF, 1, 6};
    vecs[8]  = '{0, 4'h3, 4'h7, 4'h8, 8'hF0, 8'h3C, 8'hCC, 8'h00, 8'hAF, 1, 6};
    vecs[9]  = '{0, 4'hE, 4'h9, 4'hA, 8'h81, 8'h0E, 8'h02, 8'h01, 8'h01, 2, 8};
    vecs[10] = '{1, 4'h6, 4'h9, 4'hA, 8'h81, 8'h0E, 8'h07, 8'h00, 8'h00, 2, 8};
    vecs[11] = '{1, 4'hE, 4'h9, 4'hA, 8'h0E, 8'h81, 8'h02, 8'h01, 8'h01, 2, 8};
    vecs[12] = '{0, 4'h4, 4'h1, 4'h2, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 2, 8};
    vecs[13] = '{0, 4'h5, 4'h3, 4'h4, 8'h07, 8'h07, 8'h00, 8'h01, 8'h01, 2, 8};
    vecs[14] = '{0, 4'h4, 4'hF, 4'h2, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h01, 2, 8};
    vecs[15] = '{1, 4'h4, 4'h1, 4'h2, 8'h80, 8'h80, 8'h00, 8'h01, 8'h01, 2, 8};
    vecs[16] = '{0, 4'h6, 4'h9, 4'hA, 8'h81, 8'h0E, 8'h40, 8'h01, 8'h01, 2, 8};

    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; opn_s[d] = 4'h0; opx_s[d] = 4'h0; opy_s[d] = 4'h0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset busy d%0d", d), 32'(busy_o[d]), 32'(0));
      chk($sformatf("reset done d%0d", d), 32'(done_o[d]), 32'(0));
      chk($sformatf("reset illegal d%0d", d), 32'(ill_o[d]), 32'(0));
      chk($sformatf("reset we d%0d", d), 32'(we_o[d]), 32'(0));
      chk($sformatf("reset alu_sel d%0d", d), 32'(sel_o[d]), 32'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) apply(vecs[i], 0);

    // Starts during busy (mid-op and in DONE) are ignored
    apply(vecs[0], 3);
    apply(vecs[4], 6);

    // Illegal N: one-cycle pulse, no writes, busy clears the next cycle
    begin
      preload(0, 4'h1, 4'h2, 8'h55, 8'h66);
      wlog.delete();
      start_s[0] = 1'b1; opn_s[0] = 4'h9; opx_s[0] = 4'h1; opy_s[0] = 4'h2;
      @(negedge clk);
      start_s[0] = 1'b0;
      chk("illegal pulse c1", 32'(ill_o[0]), 32'(1));
      chk("illegal busy c1", 32'(busy_o[0]), 32'(1));
      chk("illegal done c1", 32'(done_o[0]), 32'(0));
      @(negedge clk);
      chk("illegal pulse c2", 32'(ill_o[0]), 32'(0));
      chk("illegal busy c2", 32'(busy_o[0]), 32'(0));
      repeat (8) @(negedge clk);
      chk("illegal writes", 32'(wlog.size()), 32'(0));
      chk("illegal v1 kept", 32'(rf[0][1]), 32'h55);
    end

    // Reset asserted during WR_X abandons the write
    begin
      preload(0, 4'h1, 4'h2, 8'hF0, 8'h20);
      wlog.delete();
      start_s[0] = 1'b1; opn_s[0] = 4'h4; opx_s[0] = 4'h1; opy_s[0] = 4'h2;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (5) @(negedge clk);
      chk("wr_x we before reset", 32'(we_o[0]), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("reset mid-op we", 32'(we_o[0]), 32'(0));
      chk("reset mid-op busy", 32'(busy_o[0]), 32'(0));
      @(negedge clk);
      chk("reset mid-op writes", 32'(wlog.size()), 32'(0));
      chk("reset mid-op v1", 32'(rf[0][1]), 32'hF0);
      rst_n = 1'b1;
      @(negedge clk);
      apply('{0, 4'h0, 4'h1, 4'h2, 8'hF0, 8'h20, 8'h20, 8'h00, 8'hAF, 1, 6}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
